riscv_imem_loader: RTL

//  Instruction-load sequencer between the AXI4-Lite slave register file and the single-cycle RISC-V core.
//  It turns level-held software register values into single-cycle instruction-memory write strobes.
//  It can sweep-clear instruction memory, and it gates core execution through mem_reset_n / run_pc.
//  It stops the core while software is loading a program and releases it cleanly.

---
 rtl/riscv_imem_loader_if.sv | 35 +++
 rtl/riscv_imem_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_imem_loader_if.sv
// ============================================================================
// riscv_imem_loader_if : register-side inputs and imem/core-side outputs of the loader
// Rev 1.0
// ============================================================================
`default_nettype none

interface riscv_imem_loader_if #(
  parameter int IMEM_AW    = 10,
  parameter int DATA_WIDTH = 32
);
  logic [31:0]            i_ctrl;
  logic                   i_wr_req;
  logic [DATA_WIDTH-1:0]  i_wr_data;
  logic [31:0]            i_wr_addr;
  logic                   o_imem_we;
  logic [IMEM_AW-1:0]     o_imem_addr;
  logic [DATA_WIDTH-1:0]  o_imem_wdata;
  logic                   o_mem_reset_n;
  logic                   o_run_pc;
  logic [31:0]            o_status;

  // Software/register-file side
  modport master (
    output i_ctrl, i_wr_req, i_wr_data, i_wr_addr,
    input  o_imem_we, o_imem_addr, o_imem_wdata, o_mem_reset_n, o_run_pc, o_status
  );

  // Loader side
  modport slave (
    input  i_ctrl, i_wr_req, i_wr_data, i_wr_addr,
    output o_imem_we, o_imem_addr, o_imem_wdata, o_mem_reset_n, o_run_pc, o_status
  );
endinterface

`default_nettype wire

// File: rtl/riscv_imem_loader.sv
// ============================================================================
// riscv_imem_loader : turns level-held register values into imem write strobes,
//                     sweep-clears imem and gates core execution
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_imem_loader #(
  parameter int IMEM_AW    = 10,
  parameter int DATA_WIDTH = 32
) (
  input  wire                  s00_axi_aclk,
  input  wire                  s00_axi_aresetn,
  riscv_imem_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   req_q;
  logic                   pend_q;
  logic [IMEM_AW-1:0]     pend_addr_q;
  logic [DATA_WIDTH-1:0]  pend_data_q;
  logic                   we_q;
  logic [IMEM_AW-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   mrn_q;
  logic                   run_pc_q;
  logic                   err_q;
  logic [15:0]            cnt_q;
  logic [15:0]            cnt_d;
  logic [2:0]             stat_q;

  logic w_load_en;
  logic w_run_en;
  logic w_clear_req;
  logic w_rise;
  logic w_bad_addr;
  logic w_unused_ctrl;

  assign w_load_en     = bus.i_ctrl[0];
  assign w_run_en      = bus.i_ctrl[1];
  assign w_clear_req   = bus.i_ctrl[2];
  assign w_unused_ctrl = ^bus.i_ctrl[31:3];

  assign w_rise     = bus.i_wr_req & ~req_q;
  assign w_bad_addr = (bus.i_wr_addr[1:0] != 2'b00) || (bus.i_wr_addr[31:IMEM_AW+2] != '0);
  assign cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mrn_q       <= 1'b0;
      run_pc_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      stat_q      <= '0;
    end else begin
      req_q  <= bus.i_wr_req;
      mrn_q  <= 1'b1;
      we_q   <= 1'b0;
      pend_q <= 1'b0;

      // A write captured on the previous edge is issued now, one edge after the rise
      if (pend_q) begin
        we_q    <= 1'b1;
        addr_q  <= pend_addr_q;
        wdata_q <= pend_data_q;
        cnt_q   <= cnt_d;
      end

      case (state_q)
        S_IDLE: begin
          if (w_clear_req) begin
            state_q <= S_CLEAR;
            stat_q  <= 3'b001;
            we_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
          end else if (w_load_en) begin
            state_q <= S_LOAD;
            stat_q  <= 3'b010;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end else if (w_run_en) begin
            state_q <= S_RUN;
            stat_q  <= 3'b100;
            mrn_q   <= 1'b0;
          end
        end

        S_CLEAR: begin
          if (addr_q == '1) begin
            state_q <= S_IDLE;
            stat_q  <= 3'b000;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= addr_q + IMEM_AW'(1);
          end
        end

        S_LOAD: begin
          // A rise coinciding with load_en falling is dropped silently
          if (!w_load_en) begin
            state_q <= S_IDLE;
            stat_q  <= 3'b000;
          end else if (w_rise) begin
            if (w_bad_addr) begin
              err_q <= 1'b1;
            end else begin
              pend_q      <= 1'b1;
              pend_addr_q <= bus.i_wr_addr[IMEM_AW+1:2];
              pend_data_q <= bus.i_wr_data;
            end
          end
        end

        S_RUN: begin
          if (!w_run_en) begin
            state_q  <= S_IDLE;
            stat_q   <= 3'b000;
            run_pc_q <= 1'b0;
          end else begin
            run_pc_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          stat_q  <= 3'b000;
        end
      endcase
    end
  end

  assign bus.o_imem_we     = we_q;
  assign bus.o_imem_addr   = addr_q;
  assign bus.o_imem_wdata  = wdata_q;
  assign bus.o_mem_reset_n = mrn_q;
  assign bus.o_run_pc      = run_pc_q;
  assign bus.o_status      = {cnt_q, 12'h000, err_q, stat_q};

endmodule

`default_nettype wire
